// File: rtl/filter_out_capture.sv
// filter_out_capture: armed, magnitude-triggered capture of a filter output stream with peak tracking.
// Optional CAPTURE_ENERGY_EN adds an `energy` output (sum of squares of captured samples).
module filter_out_capture #(
    parameter int DATA_W = 18,
    parameter int ADDR_W = 7
) (
    input  logic                     sys_clk,
    input  logic                     reset,
    input  logic                     sam_clk_en,
    input  logic signed [DATA_W-1:0] y_in,
    input  logic                     arm,
    input  logic        [DATA_W-2:0] thresh,
    input  logic        [ADDR_W-1:0] rd_addr,
    output logic signed [DATA_W-1:0] rd_data,
    output logic                     busy,
    output logic                     done,
    output logic        [DATA_W-2:0] peak_mag,
    output logic        [ADDR_W-1:0] peak_idx
`ifdef CAPTURE_ENERGY_EN
    ,
    output logic [2*DATA_W+ADDR_W-1:0] energy
`endif
);
    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;
    state_t r_state, w_next;
    logic signed [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [DATA_W-2:0] r_peak_mag;
    logic [ADDR_W-1:0] r_peak_idx;
    logic signed [DATA_W-1:0] r_rd_data;
    logic r_busy, r_done;
    logic [DATA_W-1:0] w_abs;
    logic [DATA_W-2:0] w_mag;
    logic w_we;
    assign w_abs = y_in[DATA_W-1] ? -y_in : y_in;
    // Only the most negative value keeps its sign bit after negation; clamp it.
    assign w_mag = w_abs[DATA_W-1] ? '1 : w_abs[DATA_W-2:0];
    assign busy = r_busy;
    assign done = r_done;
    assign peak_mag = r_peak_mag;
    assign peak_idx = r_peak_idx;
    assign rd_data = r_rd_data;
    always_comb begin
        w_next = r_state;
        w_we = 1'b0;
        if (reset) begin
            w_next = IDLE;
        end else if (arm) begin
            w_next = ARMED;
        end else if (sam_clk_en && r_state == ARMED && w_mag >= thresh) begin
            w_we = 1'b1;
            w_next = CAPTURE;
        end else if (sam_clk_en && r_state == CAPTURE) begin
            w_we = 1'b1;
            w_next = (r_wr_ptr == '1) ? DONE : CAPTURE;
        end
    end
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_wr_ptr <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_peak_mag <= '0;
            r_peak_idx <= '0;
        end else begin
            r_state <= w_next;
            r_busy <= (w_next == ARMED) || (w_next == CAPTURE);
            r_done <= (w_next == DONE);
            if (arm) begin
                r_wr_ptr <= '0;
                r_peak_mag <= '0;
                r_peak_idx <= '0;
            end else if (w_we) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                if (r_state == ARMED || w_mag > r_peak_mag) begin
                    r_peak_mag <= w_mag;
                    r_peak_idx <= r_wr_ptr;
                end
            end
        end
    end
    always_ff @(posedge sys_clk) begin
        if (w_we) r_mem[r_wr_ptr] <= y_in;
    end
    always_ff @(posedge sys_clk) begin
        if (reset) r_rd_data <= '0;
        else r_rd_data <= r_mem[rd_addr];
    end
`ifdef CAPTURE_ENERGY_EN
    logic signed [2*DATA_W-1:0] w_y_ext;
    logic [2*DATA_W-1:0] r_prod;
    logic r_prod_v;
    logic [2*DATA_W+ADDR_W-1:0] r_energy;
    assign w_y_ext = {{DATA_W{y_in[DATA_W-1]}}, y_in};
    assign energy = r_energy;
    always_ff @(posedge sys_clk) begin
        if (reset || arm) begin
            r_prod <= '0;
            r_prod_v <= 1'b0;
            r_energy <= '0;
        end else begin
            r_prod <= w_y_ext * w_y_ext;
            r_prod_v <= w_we;
            if (r_prod_v) r_energy <= r_energy + {{ADDR_W{1'b0}}, r_prod};
        end
    end
`endif
endmodule

// File: tb/tb_filter_out_capture.sv
// tb_filter_out_capture: directed stimulus with a sample-list model checked every cycle.
module tb_filter_out_capture;
    logic sys_clk = 1'b0;
    logic reset, sam_clk_en, arm;
    logic signed [17:0] y_in;
    logic [16:0] thresh;
    logic [6:0] rd_addr;
    logic signed [17:0] rd_data;
    logic busy, done;
    logic [16:0] peak_mag;
    logic [6:0] peak_idx;
`ifdef CAPTURE_ENERGY_EN
    logic [42:0] energy;
`endif

    filter_out_capture dut (
        .sys_clk(sys_clk), .reset(reset), .sam_clk_en(sam_clk_en), .y_in(y_in),
        .arm(arm), .thresh(thresh), .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .done(done), .peak_mag(peak_mag), .peak_idx(peak_idx)
`ifdef CAPTURE_ENERGY_EN
        , .energy(energy)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    int n_chk = 0, n_fail = 0;
    bit chk_on = 0;
    int mode = 0;
    int cnt = 0;
    int mm [128];
    bit mv [128];
    int exp_rd = 0;
    bit exp_rd_v = 0;
    int done_age = 0;

    task automatic check(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int magf(input int y);
        return (y == -131072) ? 131071 : (y < 0 ? -y : y);
    endfunction

    task automatic model_step();
        exp_rd_v = reset ? 1'b1 : mv[rd_addr];
        exp_rd = reset ? 0 : mm[rd_addr];
        if (reset) begin
            mode = 0;
            cnt = 0;
        end else if (arm) begin
            mode = 1;
            cnt = 0;
        end else if (sam_clk_en) begin
            if (mode == 1 && magf(int'(y_in)) >= int'(thresh)) begin
                mm[0] = int'(y_in);
                mv[0] = 1;
                cnt = 1;
                mode = 2;
            end else if (mode == 2) begin
                mm[cnt] = int'(y_in);
                mv[cnt] = 1;
                cnt++;
                if (cnt == 128) begin
                    mode = 3;
                    done_age = -1;
                end
            end
        end
        if (mode == 3) done_age++;
    endtask

    task automatic compare_step();
        int pm, pi;
        longint en;
        pm = 0;
        pi = 0;
        en = 0;
        for (int i = 0; i < cnt; i++) begin
            if (magf(mm[i]) > pm) begin
                pm = magf(mm[i]);
                pi = i;
            end
            en += longint'(mm[i]) * longint'(mm[i]);
        end
        check("busy", longint'(busy), longint'(mode == 1 || mode == 2));
        check("done", longint'(done), longint'(mode == 3));
        check("peak_mag", longint'(peak_mag), pm);
        check("peak_idx", longint'(peak_idx), pi);
        if (exp_rd_v) check("rd_data", longint'(rd_data), exp_rd);
`ifdef CAPTURE_ENERGY_EN
        if (mode == 1 || (mode == 3 && done_age >= 1)) check("energy", longint'(energy), en);
`endif
    endtask

    initial forever begin
        @(posedge sys_clk);
        model_step();
    end

    initial forever begin
        @(negedge sys_clk);
        if (chk_on) compare_step();
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic do_arm();
        arm = 1;
        cyc(1);
        arm = 0;
    endtask

    task automatic strobe(input int y, input int gap);
        sam_clk_en = 1;
        y_in = y[17:0];
        cyc(1);
        sam_clk_en = 0;
        cyc(gap);
    endtask

    task automatic read_chk(input string nm, input int a, input int exp);
        rd_addr = a[6:0];
        cyc(1);
        check(nm, longint'(rd_data), exp);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1; sam_clk_en = 0; arm = 0; y_in = '0; thresh = '0; rd_addr = '0;
        cyc(2);
        chk_on = 1;
        check("reset_busy", longint'(busy), 0);
        check("reset_done", longint'(done), 0);
        check("reset_peak", longint'(peak_mag), 0);
        check("reset_rd", longint'(rd_data), 0);
        reset = 0;
        cyc(1);

        // 1: threshold trigger, strobe every 4th cycle
        thresh = 17'd1000;
        do_arm();
        strobe(0, 3); strobe(5, 3); strobe(-999, 3);
        check("t1_still_armed", longint'(busy), 1);
        for (int k = 1; k < 128; k++) strobe(1000 * k, 3);
        strobe(128000, 0);
        check("t1_done", longint'(done), 1);
        check("t1_busy", longint'(busy), 0);
        check("t1_peak", longint'(peak_mag), 128000);
        check("t1_idx", longint'(peak_idx), 127);
        read_chk("t1_mem0", 0, 1000);
        read_chk("t1_mem1", 1, 2000);

        // 2: saturation and strict tie rule
        thresh = '0;
        do_arm();
        for (int i = 0; i < 128; i++) strobe(i == 5 ? -131072 : (i == 9 ? 131071 : 0), 1);
        check("t2_peak", longint'(peak_mag), 131071);
        check("t2_idx", longint'(peak_idx), 5);

        // 3: ramp capture and readback sweep
        do_arm();
        for (int i = 0; i < 128; i++) strobe(i, 0);
        for (int a = 0; a < 128; a++) read_chk("t3_ramp", a, a);

        // 4: arm coincident with a qualifying sample mid-capture
        thresh = 17'd10;
        rd_addr = '0;
        do_arm();
        strobe(50, 0);
        for (int i = 1; i < 40; i++) strobe(100 + i, 0);
        arm = 1; sam_clk_en = 1; y_in = 18'sd500;
        cyc(1);
        arm = 0; sam_clk_en = 0;
        check("t4_busy", longint'(busy), 1);
        check("t4_peak_clr", longint'(peak_mag), 0);
        check("t4_idx_clr", longint'(peak_idx), 0);
        strobe(3, 1);
        check("t4_discard", longint'(peak_mag), 0);
        strobe(-20, 1);
        check("t4_trig_peak", longint'(peak_mag), 20);
        for (int i = 1; i < 128; i++) strobe(1, 0);
        check("t4_done", longint'(done), 1);
        read_chk("t4_mem0", 0, -20);
        read_chk("t4_mem40", 40, 1);

        // 5: reset mid-capture, then a normal capture (energy 128*9)
        thresh = '0;
        rd_addr = '0;
        do_arm();
        for (int i = 0; i < 10; i++) strobe(1000 + i, 0);
        reset = 1;
        cyc(1);
        reset = 0;
        check("t5_busy", longint'(busy), 0);
        check("t5_done", longint'(done), 0);
        check("t5_peak", longint'(peak_mag), 0);
        do_arm();
        check("t5_rearm", longint'(busy), 1);
        for (int i = 0; i < 128; i++) strobe(3, 0);
        check("t5_done2", longint'(done), 1);
        cyc(1);
`ifdef CAPTURE_ENERGY_EN
        check("t6_energy", longint'(energy), 1152);
`endif
        check("t5_peak2", longint'(peak_mag), 3);
        cyc(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
